// File: rtl/credit_tx_pkg.sv
// Shared sizing helpers and legal-range constants for the credit transmitter.
package credit_tx_pkg;

    localparam int CreditsMin = 1;
    localparam int CreditsMax = 15;

    // Staging pointers carry one extra bit so full and empty can be told apart.
    function automatic int ptr_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

    function automatic int crd_width(input int credits);
        return $clog2(credits + 1);
    endfunction

    function automatic bit credits_legal(input int credits);
        return (credits >= CreditsMin) && (credits <= CreditsMax);
    endfunction

endpackage

// File: rtl/credit_tx_stage.sv
// Staging queue for credit_tx: circular storage with extended read/write pointers.
module credit_tx_stage
    import credit_tx_pkg::*;
#(
    parameter int Width      = 32,
    parameter int StageDepth = 2,
    localparam int PtrW      = ptr_width(StageDepth)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             flush,
    input  logic             push,
    input  logic [Width-1:0] push_data,
    input  logic             pop,
    output logic [PtrW-1:0]  occupancy,
    output logic [Width-1:0] head,
    output logic             not_empty
);

    localparam int AddrW = PtrW - 1;

    logic [Width-1:0] mem [StageDepth];
    logic [PtrW-1:0]  wr_ptr;
    logic [PtrW-1:0]  rd_ptr;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < StageDepth; i++) begin
                mem[i] <= '0;
            end
        end else if (push && !flush) begin
            mem[wr_ptr[AddrW-1:0]] <= push_data;
        end
    end

    // Pointer difference wraps naturally modulo 2*StageDepth.
    assign occupancy = wr_ptr - rd_ptr;
    assign not_empty = (wr_ptr != rd_ptr);
    assign head      = mem[rd_ptr[AddrW-1:0]];

endmodule

// File: rtl/credit_tx.sv
// Credit-based link transmitter. Define CREDIT_TX_BYPASS_EN for the zero-latency
// combinational output path; by default the output is registered.
module credit_tx
    import credit_tx_pkg::*;
#(
    parameter int Width      = 32,
    parameter int Credits    = 2,
    parameter int StageDepth = 2
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          flush_i,
    input  logic                          in_valid_i,
    input  logic [Width-1:0]              in_data_i,
    output logic                          in_rdy_o,
    output logic                          tx_valid_o,
    output logic [Width-1:0]              tx_data_o,
    input  logic                          crd_ret_i,
    output logic [crd_width(Credits)-1:0] crd_cnt_o,
    output logic                          idle_o,
    output logic                          err_o
);

    localparam int CrdW = crd_width(Credits);
    localparam int PtrW = ptr_width(StageDepth);
    localparam logic [CrdW-1:0] CrdInit = CrdW'(Credits);

    if (!credits_legal(Credits)) begin : gen_bad_credits
        $error("credit_tx: Credits out of legal range");
    end

    logic [PtrW-1:0]  occupancy;
    logic [Width-1:0] head;
    logic             not_empty;
    logic             accept;
    logic             push;
    logic             pop;
    logic             send;
    logic             crd_avail;
    logic [CrdW-1:0]  crd_q;
    logic [CrdW:0]    crd_sum;
    logic             err_q;

    credit_tx_stage #(
        .Width      (Width),
        .StageDepth (StageDepth)
    ) u_stage (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .flush      (flush_i),
        .push       (push),
        .push_data  (in_data_i),
        .pop        (pop),
        .occupancy  (occupancy),
        .head       (head),
        .not_empty  (not_empty)
    );

    // Ready depends only on registered occupancy, so a same-cycle pop never raises it.
    assign in_rdy_o  = (occupancy < PtrW'(StageDepth));
    assign accept    = in_valid_i & in_rdy_o & ~flush_i;
    assign crd_avail = (crd_q != '0);
    assign pop       = not_empty & crd_avail & ~flush_i;

`ifdef CREDIT_TX_BYPASS_EN
    logic bypass;

    // An item arriving at an empty stage with a credit in hand goes straight out.
    assign bypass     = ~not_empty & crd_avail & in_valid_i & ~flush_i;
    assign send       = pop | bypass;
    assign push       = accept & ~bypass;
    assign tx_valid_o = send;
    assign tx_data_o  = not_empty ? head : in_data_i;
`else
    assign send = pop;
    assign push = accept;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tx_valid_o <= 1'b0;
            tx_data_o  <= '0;
        end else if (flush_i) begin
            tx_valid_o <= 1'b0;
            tx_data_o  <= '0;
        end else begin
            tx_valid_o <= send;
            if (send) begin
                tx_data_o <= head;
            end
        end
    end
`endif

    // Widened by one bit so a return at full count is visible as overflow.
    assign crd_sum = {1'b0, crd_q} + (CrdW+1)'(crd_ret_i) - (CrdW+1)'(send);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            crd_q <= CrdInit;
            err_q <= 1'b0;
        end else if (flush_i) begin
            crd_q <= CrdInit;
            err_q <= 1'b0;
        end else if (crd_sum > (CrdW+1)'(Credits)) begin
            crd_q <= CrdInit;
            err_q <= 1'b1;
        end else begin
            crd_q <= crd_sum[CrdW-1:0];
        end
    end

    assign crd_cnt_o = crd_q;
    assign err_o     = err_q;
    assign idle_o    = ~not_empty & (crd_q == CrdInit) & ~tx_valid_o;

endmodule

// File: tb/tb_credit_tx.sv
// Scoreboard bench for credit_tx: directed vectors push expected items, a monitor checks tx pulses.
`timescale 1ns/1ps
module tb_credit_tx;

    localparam int Width      = 32;
    localparam int Credits    = 2;
    localparam int StageDepth = 2;
    localparam int CrdW       = 2;

    logic             clk_i      = 1'b0;
    logic             rst_ni     = 1'b0;
    logic             flush_i    = 1'b0;
    logic             in_valid_i = 1'b0;
    logic [Width-1:0] in_data_i  = '0;
    logic             crd_ret_i  = 1'b0;
    logic             in_rdy_o;
    logic             tx_valid_o;
    logic [Width-1:0] tx_data_o;
    logic [CrdW-1:0]  crd_cnt_o;
    logic             idle_o;
    logic             err_o;

    int assertCount = 0;
    int failCount   = 0;
    logic [Width-1:0] expQ[$];

    always #5 clk_i = ~clk_i;

    credit_tx #(
        .Width      (Width),
        .Credits    (Credits),
        .StageDepth (StageDepth)
    ) dut (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .flush_i    (flush_i),
        .in_valid_i (in_valid_i),
        .in_data_i  (in_data_i),
        .in_rdy_o   (in_rdy_o),
        .tx_valid_o (tx_valid_o),
        .tx_data_o  (tx_data_o),
        .crd_ret_i  (crd_ret_i),
        .crd_cnt_o  (crd_cnt_o),
        .idle_o     (idle_o),
        .err_o      (err_o)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: actual 0x%0h required 0x%0h", name, actual, expected);
        end
    endtask

    // One cycle: drive just after the edge, return at the following negedge.
    task automatic applyStimulus(input logic valid, input logic [31:0] data, input logic ret,
                                 input logic flush, input logic track, output logic accepted);
        @(posedge clk_i);
        #1;
        in_valid_i = valid;
        in_data_i  = data;
        crd_ret_i  = ret;
        flush_i    = flush;
        accepted   = valid & in_rdy_o & ~flush;
        if (accepted && track) begin
            expQ.push_back(data);
        end
        @(negedge clk_i);
    endtask

    always @(negedge clk_i) begin
        if (rst_ni && tx_valid_o) begin
            if (expQ.size() == 0) begin
                assertCount++;
                failCount++;
                $display("[TB] FAIL unexpected_tx: actual pulse data 0x%0h required no pulse", tx_data_o);
            end else begin
                checkOutput("tx_data", tx_data_o, expQ.pop_front());
            end
        end
    end

    initial begin
        repeat (5000) @(posedge clk_i);
        $display("[TB] FAIL watchdog: actual timeout required test completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic acc;
        logic saw;
        int   idx;
        logic [31:0] items [6];

        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        checkOutput("in_reset tx_valid", tx_valid_o, 0);
        checkOutput("in_reset crd_cnt", crd_cnt_o, 2);
        @(posedge clk_i);
        #1 rst_ni = 1'b1;
        @(negedge clk_i);
        checkOutput("reset crd_cnt", crd_cnt_o, 2);
        checkOutput("reset in_rdy", in_rdy_o, 1);
        checkOutput("reset idle", idle_o, 1);
        checkOutput("reset tx_valid", tx_valid_o, 0);
        checkOutput("reset tx_data", tx_data_o, 0);
        checkOutput("reset err", err_o, 0);

`ifndef CREDIT_TX_BYPASS_EN
        $display("[TB] credit exhaustion");
        applyStimulus(1, 32'hA, 0, 0, 1, acc);
        checkOutput("exh accept A", acc, 1);
        applyStimulus(1, 32'hB, 0, 0, 1, acc);
        checkOutput("exh accept B", acc, 1);
        applyStimulus(1, 32'hC, 0, 0, 1, acc);
        checkOutput("exh tx A valid", tx_valid_o, 1);
        checkOutput("exh crd after A", crd_cnt_o, 1);
        applyStimulus(0, 0, 0, 0, 0, acc);
        checkOutput("exh tx B valid", tx_valid_o, 1);
        checkOutput("exh crd empty", crd_cnt_o, 0);
        applyStimulus(0, 0, 0, 0, 0, acc);
        checkOutput("exh C held", tx_valid_o, 0);
        checkOutput("exh idle low", idle_o, 0);
        applyStimulus(0, 0, 0, 0, 0, acc);
        checkOutput("exh C still held", tx_valid_o, 0);
        applyStimulus(0, 0, 1, 0, 0, acc);
        checkOutput("exh ret cycle tx", tx_valid_o, 0);
        checkOutput("exh ret cycle crd", crd_cnt_o, 0);
        applyStimulus(0, 0, 0, 0, 0, acc);
        checkOutput("exh crd returned", crd_cnt_o, 1);
        checkOutput("exh send cycle tx", tx_valid_o, 0);
        applyStimulus(0, 0, 0, 0, 0, acc);
        checkOutput("exh tx C valid", tx_valid_o, 1);
        checkOutput("exh crd after C", crd_cnt_o, 0);
        applyStimulus(0, 0, 1, 0, 0, acc);
        applyStimulus(0, 0, 1, 0, 0, acc);
        applyStimulus(0, 0, 0, 0, 0, acc);
        checkOutput("exh crd home", crd_cnt_o, 2);
        checkOutput("exh idle", idle_o, 1);

        $display("[TB] overflow");
        applyStimulus(0, 0, 1, 0, 0, acc);
        checkOutput("ovf before err", err_o, 0);
        applyStimulus(0, 0, 0, 0, 0, acc);
        checkOutput("ovf err set", err_o, 1);
        checkOutput("ovf crd saturated", crd_cnt_o, 2);
        applyStimulus(0, 0, 0, 0, 0, acc);
        checkOutput("ovf err sticky", err_o, 1);
        applyStimulus(0, 0, 0, 1, 0, acc);
        applyStimulus(0, 0, 0, 0, 0, acc);
        checkOutput("ovf err flushed", err_o, 0);

        $display("[TB] staging full");
        applyStimulus(1, 32'hD, 0, 0, 1, acc);
        applyStimulus(1, 32'hE, 0, 0, 1, acc);
        applyStimulus(1, 32'hF, 0, 0, 0, acc);
        checkOutput("full accept F", acc, 1);
        applyStimulus(1, 32'h10, 0, 0, 0, acc);
        checkOutput("full accept G", acc, 1);
        checkOutput("full crd zero", crd_cnt_o, 0);
        applyStimulus(1, 32'h11, 0, 0, 0, acc);
        checkOutput("full in_rdy low", in_rdy_o, 0);
        checkOutput("full third held", acc, 0);
        applyStimulus(1, 32'h11, 0, 0, 0, acc);
        checkOutput("full in_rdy still low", in_rdy_o, 0);
        checkOutput("full no tx", tx_valid_o, 0);

        $display("[TB] flush mid-stream");
        applyStimulus(1, 32'h11, 1, 1, 0, acc);
        checkOutput("flush cycle crd", crd_cnt_o, 0);
        applyStimulus(0, 0, 0, 0, 0, acc);
        checkOutput("flush crd restored", crd_cnt_o, 2);
        checkOutput("flush in_rdy", in_rdy_o, 1);
        checkOutput("flush idle", idle_o, 1);
        checkOutput("flush err", err_o, 0);
        checkOutput("flush no tx", tx_valid_o, 0);
        applyStimulus(0, 0, 0, 0, 0, acc);
        checkOutput("flush still no tx", tx_valid_o, 0);
        checkOutput("flush crd stable", crd_cnt_o, 2);
`else
        $display("[TB] bypass");
        applyStimulus(1, 32'h55, 0, 0, 1, acc);
        checkOutput("byp tx_valid", tx_valid_o, 1);
        checkOutput("byp tx_data", tx_data_o, 32'h55);
        checkOutput("byp crd before", crd_cnt_o, 2);
        applyStimulus(0, 0, 0, 0, 0, acc);
        checkOutput("byp crd spent", crd_cnt_o, 1);
        checkOutput("byp idle low", idle_o, 0);
        checkOutput("byp single pulse", tx_valid_o, 0);
        applyStimulus(0, 0, 1, 0, 0, acc);
        applyStimulus(0, 0, 0, 0, 0, acc);
        checkOutput("byp crd home", crd_cnt_o, 2);
        checkOutput("byp idle", idle_o, 1);
`endif

        $display("[TB] burst with credit loopback");
        for (int i = 0; i < 6; i++) begin
            items[i] = 32'h100 + 32'(i);
        end
        idx = 0;
        saw = 1'b0;
        for (int c = 0; c < 60 && idx < 6; c++) begin
            applyStimulus(1, items[idx], saw, 0, 1, acc);
            saw = tx_valid_o;
            if (acc) begin
                idx++;
            end
        end
        checkOutput("burst all accepted", idx, 6);
        for (int c = 0; c < 60 && (expQ.size() != 0 || saw || crd_cnt_o != 2); c++) begin
            applyStimulus(0, 0, saw, 0, 0, acc);
            saw = tx_valid_o;
        end
        checkOutput("burst drained", expQ.size(), 0);
        checkOutput("burst crd home", crd_cnt_o, 2);
        checkOutput("burst idle", idle_o, 1);
        checkOutput("burst no err", err_o, 0);

        $display("[TB] End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
